// File: rtl/shift_link_pkg.sv
// Shared definitions for the serial bit link (receiver and serializer sides).
package shift_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to hold a count from 0 up to and including w.
  function automatic int count_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_to_parallel_receiver_if.sv
// Link-side and consumer-side signals of the serial-to-parallel receiver.
interface serial_to_parallel_receiver_if #(
  parameter int WIDTH = shift_link_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic             sin;
  logic             sin_valid;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output start, sin, sin_valid, dout_ready,
    input  dout, dout_valid, busy, overrun, parity_err
  );

  modport slave (
    input  start, sin, sin_valid, dout_ready,
    output dout, dout_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/serial_to_parallel_receiver_bit_counter.sv
// Frame bit counter: synchronous clear, enable, saturates at WIDTH.
module bit_counter
  import shift_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = count_w(WIDTH);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CW'(WIDTH))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Flags the enabled bit that brings the count to WIDTH.
  assign o_tc = i_en && (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_to_parallel_receiver.sv
// Serial-to-parallel receiver with valid/ready output handshake.
// Optional even-parity bit after each word when PARITY_CHECK_EN is defined.
module serial_to_parallel_receiver
  import shift_link_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                          clock,
  input logic                          reset,
  serial_to_parallel_receiver_if.slave bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_busy;
  logic             r_overrun;
  logic [WIDTH-1:0] w_sreg_shift;
  logic             w_handshake;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_last_bit;

  always_comb begin
    w_sreg_shift = {bus.sin, r_sreg[WIDTH-1:1]};
    if (MSB_FIRST) begin
      w_sreg_shift = {r_sreg[WIDTH-2:0], bus.sin};
    end
  end

  assign w_handshake = r_dout_valid && bus.dout_ready;
  // Any accepted start re-arms the count; leaving HOLD clears it as well.
  assign w_cnt_clr   = (bus.start && (r_state != HOLD)) || w_handshake;
  assign w_cnt_en    = (r_state == SHIFT) && bus.sin_valid && !bus.start;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clock (clock),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_last_bit)
  );

`ifdef PARITY_CHECK_EN
  logic r_parity_err;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sreg       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= SHIFT;
            r_busy  <= 1'b1;
            r_sreg  <= '0;
          end
        end
        SHIFT: begin
          if (bus.start) begin
            r_sreg <= '0;
          end else if (bus.sin_valid) begin
            r_sreg <= w_sreg_shift;
            if (w_last_bit) begin
`ifdef PARITY_CHECK_EN
              r_state <= PARITY;
`else
              r_state      <= HOLD;
              r_busy       <= 1'b0;
              r_dout       <= w_sreg_shift;
              r_dout_valid <= 1'b1;
`endif
            end
          end
        end
        PARITY: begin
`ifdef PARITY_CHECK_EN
          if (bus.start) begin
            r_state <= SHIFT;
            r_sreg  <= '0;
          end else if (bus.sin_valid) begin
            r_state      <= HOLD;
            r_busy       <= 1'b0;
            r_dout       <= r_sreg;
            r_dout_valid <= 1'b1;
            r_parity_err <= (^r_sreg) ^ bus.sin;
          end
`else
          r_state <= IDLE;
`endif
        end
        HOLD: begin
          // Bits arriving while the word waits are dropped and flagged.
          if (bus.sin_valid) begin
            r_overrun <= 1'b1;
          end
          if (w_handshake) begin
            r_dout_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_parity_err <= 1'b0;
`endif
            if (bus.start) begin
              r_state <= SHIFT;
              r_busy  <= 1'b1;
              r_sreg  <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Bench for serial_to_parallel_receiver: LSB-first and MSB-first instances
// driven in parallel, checked against a frame-level model every cycle.
module tb_serial_to_parallel_receiver;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic st = 1'b0, sv = 1'b0, s = 1'b0, rdy = 1'b0;

  always #5 clk = ~clk;

  serial_to_parallel_receiver_if #(.WIDTH(W)) ifl ();
  serial_to_parallel_receiver_if #(.WIDTH(W)) ifm ();

  assign ifl.start = st;  assign ifl.sin = s;  assign ifl.sin_valid = sv;  assign ifl.dout_ready = rdy;
  assign ifm.start = st;  assign ifm.sin = s;  assign ifm.sin_valid = sv;  assign ifm.dout_ready = rdy;

  serial_to_parallel_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clock (clk), .reset (rst), .bus (ifl)
  );
  serial_to_parallel_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clock (clk), .reset (rst), .bus (ifm)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model: collected bits in arrival order, word built on completion.
  bit       m_active, m_hold, m_dv, m_busy, m_ovr, m_perr, m_dout_known;
  bit       m_bits[$];
  bit [W-1:0] m_dout_l, m_dout_m;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit xor_bits();
    bit x = 1'b0;
    foreach (m_bits[i]) x ^= m_bits[i];
    return x;
  endfunction

  task automatic finish_frame(input bit p);
    m_dout_l = '0;
    m_dout_m = '0;
    for (int i = 0; i < W; i++) begin
      m_dout_l = m_dout_l + (m_bits[i] ? (W'(1) << i) : W'(0));
      m_dout_m = m_dout_m + (m_bits[i] ? (W'(1) << (W - 1 - i)) : W'(0));
    end
    m_active = 1'b0;
    m_hold   = 1'b1;
    m_dv     = 1'b1;
    m_perr   = p;
    m_dout_known = 1'b1;
  endtask

  task automatic model_update();
    if (rst) begin
      m_active = 0; m_hold = 0; m_dv = 0; m_ovr = 0; m_perr = 0;
      m_dout_l = '0; m_dout_m = '0; m_dout_known = 1'b1;
      m_bits.delete();
    end else if (m_hold) begin
      if (sv) m_ovr = 1'b1;
      if (rdy) begin
        m_hold = 0; m_dv = 0; m_perr = 0; m_dout_known = 1'b0;
        if (st) begin
          m_active = 1'b1;
          m_bits.delete();
        end
      end
    end else if (m_active) begin
      if (st) begin
        m_bits.delete();
      end else if (sv) begin
`ifdef PARITY_CHECK_EN
        if (m_bits.size() == W) finish_frame(xor_bits() ^ s);
        else m_bits.push_back(s);
`else
        m_bits.push_back(s);
        if (m_bits.size() == W) finish_frame(1'b0);
`endif
      end
    end else if (st) begin
      m_active = 1'b1;
      m_bits.delete();
    end
    m_busy = m_active;
  endtask

  task automatic compare();
    chk("dv_lsb", ifl.dout_valid, m_dv);
    chk("dv_msb", ifm.dout_valid, m_dv);
    chk("busy_lsb", ifl.busy, m_busy);
    chk("busy_msb", ifm.busy, m_busy);
    chk("ovr_lsb", ifl.overrun, m_ovr);
    chk("ovr_msb", ifm.overrun, m_ovr);
    chk("perr_lsb", ifl.parity_err, m_perr);
    chk("perr_msb", ifm.parity_err, m_perr);
    if (m_dout_known) begin
      chk("dout_lsb", ifl.dout, m_dout_l);
      chk("dout_msb", ifm.dout, m_dout_m);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
    st = 0; sv = 0; s = 0; rst = 0;
  endtask

  // b[i] is the i-th transmitted bit; gap idle cycles precede every bit.
  task automatic send_frame(input logic [W-1:0] b, input int gap, input bit par_flip);
    st = 1'b1;
    step();
    for (int i = 0; i < W; i++) begin
      repeat (gap) step();
      sv = 1'b1; s = b[i];
      step();
    end
`ifdef PARITY_CHECK_EN
    repeat (gap) step();
    sv = 1'b1; s = (^b) ^ par_flip;
    step();
`endif
  endtask

  task automatic accept();
    rdy = 1'b1;
    step();
    rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step();
    chk("rst_dout", ifl.dout, 0);
    chk("rst_dv", ifl.dout_valid, 0);
    chk("rst_busy", ifl.busy, 0);

    // Directed frame 1,0,1,1,0,0,1,0 on consecutive cycles.
    send_frame(8'b0100_1101, 0, 1'b0);
    chk("t1_lat_dv", ifl.dout_valid, 1);
    chk("t1_dout_lsb", ifl.dout, 8'h4D);
    chk("t2_dout_msb", ifm.dout, 8'hB2);
    chk("model_lsb", m_dout_l, 8'h4D);
    chk("model_msb", m_dout_m, 8'hB2);
    accept();

    // Sparse bits, then an overrun while the word waits.
    send_frame(8'b0100_1101, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin sv = 1'b1; s = 1'b1; end
      step();
    end
    chk("t3_dout", ifl.dout, 8'h4D);
    chk("t3_ovr", ifl.overrun, 1);
    chk("t3_dv", ifl.dout_valid, 1);
    accept();
    chk("t3_busy", ifl.busy, 0);
    chk("t3_dv_clr", ifl.dout_valid, 0);

    // Restart mid-frame discards the partial word.
    st = 1'b1; step();
    for (int i = 0; i < 3; i++) begin sv = 1'b1; s = 1'b0; step(); end
    send_frame(8'hFF, 0, 1'b0);
    chk("t4_dout_lsb", ifl.dout, 8'hFF);
    chk("t4_dout_msb", ifm.dout, 8'hFF);
    accept();

    // Reset mid-frame, then a clean frame.
    st = 1'b1; step();
    for (int i = 0; i < 4; i++) begin sv = 1'b1; s = 1'b1; step(); end
    rst = 1'b1; step();
    chk("t5_busy", ifl.busy, 0);
    chk("t5_ovr", ifl.overrun, 0);
    chk("t5_dout", ifl.dout, 0);
    send_frame(8'b0100_1101, 0, 1'b0);
    chk("t5_dout_lsb", ifl.dout, 8'h4D);
    accept();

`ifdef PARITY_CHECK_EN
    send_frame(8'b0100_1101, 0, 1'b0);
    chk("t6_perr0", ifl.parity_err, 0);
    chk("t6_dout0", ifl.dout, 8'h4D);
    accept();
    send_frame(8'b0100_1101, 0, 1'b1);
    chk("t6_perr1", ifl.parity_err, 1);
    chk("t6_dout1", ifl.dout, 8'h4D);
    accept();
`endif

    // Randomised traffic: restarts, gaps, back-pressure, overruns, resets.
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 39) == 0);
      sv  = $urandom_range(0, 1);
      s   = $urandom_range(0, 1);
      rdy = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
